// File: rtl/axi_uart_lite.sv
// AXI4-Lite slave 8N1 UART transmitter: TX FIFO, programmable baud divisor, status register.
// Latency: B one cycle after the later AW/W handshake, R one cycle after AR; tx start bit 2 cycles after push.
// Backpressure: one outstanding access per channel; a TXDATA write into a full FIFO drops the byte with SLVERR.
module axi_uart_lite #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        tx
);
    localparam int         PTR_W       = $clog2(FIFO_DEPTH);
    localparam int         CNT_W       = PTR_W + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    w_state_t   w_state, w_next;
    r_state_t   r_state, r_next;
    tx_state_t  tx_state, tx_state_next;

    logic [15:0]      div;
    logic [1:0]       aw_addr_q, wr_addr, wr_resp;
    logic [15:0]      w_dat_q, wr_dat;
    logic [1:0]       w_strb_q, wr_strb;
    logic             aw_hs, w_hs, ar_hs, wr_fire;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]      status, rd_dat;
    logic [1:0]       rd_resp;
    logic [9:0]       tx_sh;
    logic [15:0]      tx_div, baud_cnt;
    logic [3:0]       bit_cnt;
    logic             baud_end, tx_busy;
    logic             unused_bits;

    assign unused_bits = ^{awaddr[31:4], awaddr[1:0], araddr[31:4], araddr[1:0], wdata[31:16], wstrb[3:2]};

    // Write channel FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) w_next = W_RESP;
                else if (awvalid)      w_next = W_WAIT_DATA;
                else if (wvalid)       w_next = W_WAIT_ADDR;
            end
            W_WAIT_DATA: begin
                wready = 1'b1;
                if (wvalid) w_next = W_RESP;
            end
            W_WAIT_ADDR: begin
                awready = 1'b1;
                if (awvalid) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign wr_fire = (w_state != W_RESP) && (w_next == W_RESP);
    // Whichever half arrives last is taken straight from the bus, the other from its holding register.
    assign wr_addr = aw_hs ? awaddr[3:2] : aw_addr_q;
    assign wr_dat  = w_hs ? wdata[15:0] : w_dat_q;
    assign wr_strb = w_hs ? wstrb[1:0] : w_strb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_addr_q <= 2'd0;
            w_dat_q   <= 16'd0;
            w_strb_q  <= 2'd0;
        end else begin
            if (aw_hs) aw_addr_q <= awaddr[3:2];
            if (w_hs) begin
                w_dat_q  <= wdata[15:0];
                w_strb_q <= wstrb[1:0];
            end
        end
    end

    always_comb begin
        wr_resp   = RESP_OKAY;
        fifo_push = 1'b0;
        case (wr_addr)
            2'd0: begin
                if (wr_strb[0]) begin
                    if (fifo_full) wr_resp = RESP_SLVERR;
                    else           fifo_push = wr_fire;
                end
            end
            2'd2:    wr_resp = RESP_OKAY;
            default: wr_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bresp <= RESP_OKAY;
            div   <= DIV_RESET;
        end else if (wr_fire) begin
            bresp <= wr_resp;
            if (wr_addr == 2'd2) begin
                if (wr_strb[0]) div[7:0]  <= wr_dat[7:0];
                if (wr_strb[1]) div[15:8] <= wr_dat[15:8];
            end
        end
    end

    // Read channel FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs  = arvalid && arready;
    assign status = {16'h0, 8'(fifo_count), 5'h0, tx_busy, fifo_empty, fifo_full};

    always_comb begin
        rd_dat  = 32'h0;
        rd_resp = RESP_OKAY;
        case (araddr[3:2])
            2'd1:    rd_dat = status;
            2'd2:    rd_dat = {16'h0, div};
            2'd3:    rd_resp = RESP_SLVERR;
            default: rd_dat = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= rd_dat;
            rresp <= rd_resp;
        end
    end

    // TX FIFO; full is the registered state, so a same-cycle pop never makes room for a push.
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= wr_dat[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // TX engine
    assign tx_busy  = (tx_state == TX_SHIFT);
    assign baud_end = (baud_cnt == tx_div - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        fifo_pop      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_state_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (baud_end && bit_cnt == 4'd9) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // tx is registered so the line is glitch-free; it trails the engine state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_sh    <= '1;
            tx_div   <= 16'd1;
            baud_cnt <= 16'd0;
            bit_cnt  <= 4'd0;
        end else begin
            tx <= tx_busy ? tx_sh[0] : 1'b1;
            if (fifo_pop) begin
                tx_sh    <= {1'b1, fifo_mem[rd_ptr], 1'b0};
                tx_div   <= (div == 16'd0) ? 16'd1 : div;
                baud_cnt <= 16'd0;
                bit_cnt  <= 4'd0;
            end else if (tx_busy) begin
                if (baud_end) begin
                    baud_cnt <= 16'd0;
                    bit_cnt  <= bit_cnt + 4'd1;
                    tx_sh    <= {1'b1, tx_sh[9:1]};
                end else begin
                    baud_cnt <= baud_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: doc/axi_uart_lite.md
# axi_uart_lite

AXI4-Lite slave UART transmitter with a parametrised TX FIFO, a programmable baud divisor and a readable status register. It replaces the write-only, print-on-write simulation UART. It sits on the CPU's AXI4-Lite peripheral crossbar and drives a real 8N1 serial `tx` line. Reads are fully supported, and writes get back-pressure and error reporting.

## Interface
- `FIFO_DEPTH`, 16: TX FIFO entries; must be a power of two, ≥2.
- `DIV_RESET`, 16'd16: reset value of the baud divisor (clk cycles per bit).
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high; all state clears immediately on assertion.
- `awvalid` in 1, `awready` out 1, `awaddr` in 32: write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 32, `wstrb` in 4: write data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: write response channel.
- `arvalid` in 1, `arready` out 1, `araddr` in 32: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2: read data channel.
- `tx` out 1: serial output, idle high.

## Operation
- Register map, decoded on `addr[3:2]`; higher bits are ignored.
  - 0x0 TXDATA (WO): a write with `wstrb[0]=1` pushes `wdata[7:0]`. A read returns 0 with OKAY.
  - 0x4 STATUS (RO): bit0 full, bit1 empty, bit2 tx_busy, bits[15:8] FIFO count (zero-extended). Writing it returns SLVERR.
  - 0x8 DIV (RW): bits[15:0]; each byte is written per `wstrb[1:0]`. A divisor of 0 is treated as 1.
  - 0xC: unmapped; read returns 0 with SLVERR, write returns SLVERR.
- Write FSM states:
  - W_IDLE: `awready=wready=1`. Both handshakes in the same cycle → W_RESP. AW only → W_WAIT_DATA. W only → W_WAIT_ADDR.
  - W_WAIT_DATA: only `wready=1`; on W handshake → W_RESP.
  - W_WAIT_ADDR: only `awready=1`; on AW handshake → W_RESP.
  - W_RESP: `bvalid=1`; stays until `bready`, then → W_IDLE.
  - The register side-effect (push or DIV update) happens exactly once, on the cycle of entry into W_RESP.
- TXDATA write while the FIFO is full: the byte is dropped, `bresp=2'b10` (SLVERR), FIFO unchanged. Full is sampled at start of cycle; a same-cycle pop does not rescue the push.
- Read FSM states:
  - R_IDLE: `arready=1`; on AR handshake, latch `rdata`/`rresp` from current register values → R_DATA.
  - R_DATA: `rvalid=1`, `rdata`/`rresp` held stable until `rready`, then → R_IDLE.
- Read and write channels are independent and may complete in the same cycle. A STATUS read concurrent with a push reflects the pre-push count.
- TX engine states:
  - TX_IDLE: `tx=1`. If the FIFO is not empty, pop the head → TX_SHIFT.
  - TX_SHIFT: frame is start(0), data LSB first, stop(1) = 10 bits, each held DIV cycles; then → TX_IDLE.
  - The divisor is sampled at each frame start; a mid-frame DIV write takes effect on the next frame.
  - tx_busy = (state == TX_SHIFT).
- FIFO: circular buffer, `log2(FIFO_DEPTH)+1`-bit count. Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle keep the count constant.

## Timing
- Reset values:
  - `awready=wready=arready=1`, `bvalid=rvalid=0`, `bresp=rresp=0`, `rdata=0`, `tx=1`.
  - FIFO empty, DIV=DIV_RESET, all FSMs in their idle state.
- Write response: `bvalid` rises one cycle after the later of the AW/W handshakes.
- Read response: `rvalid` rises one cycle after the AR handshake.
- Back-to-back accesses: a new AW/W/AR is accepted no earlier than the cycle after the B/R handshake (max one outstanding per channel).
- Push-to-tx: a byte pushed into an idle, empty FIFO drives the start bit 2 cycles after entering W_RESP (1 cycle into FIFO, 1 cycle pop).
- Frame length is exactly 10×DIV cycles. Consecutive frames are back-to-back with 1 idle cycle between the stop bit and the next start bit.
- Reset mid-frame: `tx` returns to 1 asynchronously, and any queued data is discarded.

## Test plan
- Reset, then read STATUS → `rdata=32'h0000_0002` (empty), OKAY; read DIV → 16.
- Write 0x41 to TXDATA with DIV=4 → `bresp=0`; `tx` shows start, bits 1,0,0,0,0,0,1,0, stop, each 4 cycles; 40-cycle frame.
- Issue W 3 cycles before AW for a TXDATA write → exactly one push; `bvalid` rises the cycle after AW. Hold `bready=0` for 5 cycles → `bvalid` stays high and there is no second push.
- With DIV=65535, write FIFO_DEPTH+1 bytes (the first is popped immediately) → no error until the FIFO is full. The next write returns SLVERR and STATUS shows full=1, count=16.
- Write STATUS, write 0xC, read 0xC → all SLVERR, no state change. Read and write issued in the same cycle → both complete correctly.
- Assert `rst` mid-frame with 3 bytes queued → `tx=1` immediately; after release STATUS=0x2 and no further frame is sent.
